// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit order,
// the segment vector type and the hex glyph table.
package seg_pkg;

    typedef logic [7:0] seg_t;
    typedef logic [6:0] glyph_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs are stored active-high in g..a order, index = hex nibble.
    localparam glyph_t HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble plus decimal point to active-high segment vector.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output seg_t       seg
);

    glyph_t glyph;

    // The table is in canonical g..a order; remap here so the pin order
    // follows the SEG_* positions only.
    always_comb begin
        glyph       = HEX_TABLE[nibble];
        seg         = '0;
        seg[SEG_A]  = glyph[0];
        seg[SEG_B]  = glyph[1];
        seg[SEG_C]  = glyph[2];
        seg[SEG_D]  = glyph[3];
        seg[SEG_E]  = glyph[4];
        seg[SEG_F]  = glyph[5];
        seg[SEG_G]  = glyph[6];
        seg[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous updates.
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned DIV        = 1000,
    parameter int unsigned BLANK      = 2,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp,
    output logic [7:0]          seg_o,
    output logic [DIGITS-1:0]   an_o,
    output logic                frame_tick
);

    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic        POL   = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    dig_idx;
    logic [4*DIGITS-1:0] disp_data;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_full;
    logic                digit_end;
    logic                boundary;
    logic                in_blank;
    logic [DIGITS-1:0]   lzb_mask;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    seg_t                cur_seg;
    seg_t                seg_next;
    logic [DIGITS-1:0]   an_next;

    assign digit_end  = (div_cnt == DIV_W'(DIV - 1));
    assign boundary   = digit_end && (dig_idx == IDX_W'(DIGITS - 1));
    assign in_blank   = (32'(div_cnt) < BLANK);
    assign data_ready = !pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (digit_end) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Swap and capture are mutually exclusive: a swap needs pend_full, a
    // capture needs it clear, so a boundary-cycle accept lands in pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else if (pend_full) begin
            if (boundary) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end
        end else if (data_valid) begin
            pend_data <= data;
            pend_dp   <= dp;
            pend_full <= 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    logic lead;

    always_comb begin
        lead     = 1'b1;
        lzb_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead        = lead && (disp_data[4*i +: 4] == 4'h0) && !disp_dp[i];
            lzb_mask[i] = lead;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    assign cur_nibble = disp_data[4*dig_idx +: 4];
    assign cur_dp     = disp_dp[dig_idx];

    seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg    (cur_seg)
    );

    always_comb begin
        an_next  = '0;
        seg_next = '0;
        if (!in_blank) begin
            an_next = DIGITS'(1) << dig_idx;
            if (!lzb_mask[dig_idx]) begin
                seg_next = cur_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o      <= {8{POL}};
            an_o       <= {DIGITS{POL}};
            frame_tick <= 1'b0;
        end else begin
            seg_o      <= seg_next ^ {8{POL}};
            an_o       <= an_next ^ {DIGITS{POL}};
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed testbench for seg_scan with DIGITS=4, DIV=4, BLANK=1, active-low pins.
module tb_seg_scan;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // Expected active-low frames, packed {digit3, digit2, digit1, digit0}.
    localparam logic [31:0] F_12AF = {8'hF9, 8'hA4, 8'h88, 8'h8E};
`ifdef SEG_LZB_EN
    localparam logic [31:0] F_0003 = {8'hFF, 8'hFF, 8'hFF, 8'hB0};
    localparam logic [31:0] F_0030 = {8'hFF, 8'hFF, 8'hB0, 8'hC0};
    localparam logic [31:0] F_0000 = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
    localparam logic [31:0] F_DP2  = {8'hFF, 8'h40, 8'hC0, 8'hC0};
`else
    localparam logic [31:0] F_0003 = {8'hC0, 8'hC0, 8'hC0, 8'hB0};
    localparam logic [31:0] F_0030 = {8'hC0, 8'hC0, 8'hB0, 8'hC0};
    localparam logic [31:0] F_0000 = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
    localparam logic [31:0] F_DP2  = {8'hC0, 8'h40, 8'hC0, 8'hC0};
`endif

    seg_scan #(
        .DIGITS     (4),
        .DIV        (4),
        .BLANK      (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .dp         (dp),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step s of a frame observed right after a frame_tick: phase 0 is the blank band.
    function automatic logic [3:0] exp_an(int s);
        if (s % 4 == 0) return 4'hF;
        return ~(4'b0001 << (s / 4));
    endfunction

    function automatic logic [7:0] exp_seg(int s, logic [31:0] segs);
        if (s % 4 == 0) return 8'hFF;
        return segs[8*(s/4) +: 8];
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        data       = '0;
        dp         = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (an_o !== 4'hF || seg_o !== 8'hFF || data_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: an=%h seg=%h ready=%b tick=%b, want an=F seg=FF ready=1 tick=0",
                     an_o, seg_o, data_ready, frame_tick);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an_o !== 4'hF || seg_o !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_cycle1: an=%h seg=%h, want an=F seg=FF", an_o, seg_o);
        end
        @(negedge clk);
        checks++;
        if (an_o !== 4'hE || seg_o !== 8'hC0) begin
            errors++;
            $display("[TB] FAIL reset_cycle2: an=%h seg=%h, want an=E seg=C0", an_o, seg_o);
        end
    endtask

    task automatic test_handshake();
        int n;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hs_ready_before: ready=%b, want 1", data_ready);
        end
        data_valid = 1'b1;
        data       = 16'h12AF;
        dp         = 4'h0;
        @(negedge clk);
        data_valid = 1'b0;
        n = 0;
        do begin
            checks++;
            if (data_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hs_ready_held: ready=%b, want 0 (step %0d)", data_ready, n);
            end
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        checks++;
        if (frame_tick !== 1'b1 || data_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hs_swap: tick=%b ready=%b, want tick=1 ready=1", frame_tick, data_ready);
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            checks++;
            if (an_o !== exp_an(s) || seg_o !== exp_seg(s, F_12AF) || frame_tick !== (s == 15)) begin
                errors++;
                $display("[TB] FAIL hs_frame step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                         s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, F_12AF), (s == 15));
            end
        end
    endtask

    task automatic test_offer_full();
        int n;
        data_valid = 1'b1;
        data       = 16'h12AF;
        @(negedge clk);
        data = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (data_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL full_ready: ready=%b, want 0 (step %0d)", data_ready, i);
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_tick_timeout: tick=%b, want 1", frame_tick);
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            checks++;
            if (an_o !== exp_an(s) || seg_o !== exp_seg(s, F_12AF) || frame_tick !== (s == 15)) begin
                errors++;
                $display("[TB] FAIL full_frame step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                         s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, F_12AF), (s == 15));
            end
        end
    endtask

    task automatic test_boundary_accept();
        for (int s = 0; s < 16; s++) begin
            if (s == 15) begin
                data_valid = 1'b1;
                data       = 16'h0003;
                dp         = 4'h0;
            end
            @(negedge clk);
            checks++;
            if (an_o !== exp_an(s) || seg_o !== exp_seg(s, F_12AF) || frame_tick !== (s == 15)) begin
                errors++;
                $display("[TB] FAIL bnd_frame0 step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                         s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, F_12AF), (s == 15));
            end
        end
        data_valid = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bnd_captured: ready=%b, want 0", data_ready);
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            checks++;
            if (an_o !== exp_an(s) || seg_o !== exp_seg(s, F_12AF) || frame_tick !== (s == 15)) begin
                errors++;
                $display("[TB] FAIL bnd_no_bypass step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                         s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, F_12AF), (s == 15));
            end
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            checks++;
            if (an_o !== exp_an(s) || seg_o !== exp_seg(s, F_0003) || frame_tick !== (s == 15)) begin
                errors++;
                $display("[TB] FAIL bnd_shown step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                         s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, F_0003), (s == 15));
            end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals  [3];
        logic [3:0]  dps   [3];
        logic [31:0] frms  [3];
        int n;
        vals[0] = 16'h0030; dps[0] = 4'h0; frms[0] = F_0030;
        vals[1] = 16'h0000; dps[1] = 4'h0; frms[1] = F_0000;
        vals[2] = 16'h0000; dps[2] = 4'h4; frms[2] = F_DP2;
        for (int v = 0; v < 3; v++) begin
            data_valid = 1'b1;
            data       = vals[v];
            dp         = dps[v];
            @(negedge clk);
            data_valid = 1'b0;
            n = 0;
            while (frame_tick !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (frame_tick !== 1'b1) begin
                errors++;
                $display("[TB] FAIL lzb_tick_timeout vec %0d: tick=%b, want 1", v, frame_tick);
            end
            for (int s = 0; s < 16; s++) begin
                @(negedge clk);
                checks++;
                if (an_o !== exp_an(s) || seg_o !== exp_seg(s, frms[v]) || frame_tick !== (s == 15)) begin
                    errors++;
                    $display("[TB] FAIL lzb_frame vec %0d step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                             v, s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, frms[v]), (s == 15));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        data_valid = 1'b1;
        data       = 16'hBEEF;
        dp         = 4'h0;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_accept: ready=%b, want 0", data_ready);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an_o !== 4'hF || seg_o !== 8'hFF || data_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: an=%h seg=%h ready=%b tick=%b, want an=F seg=FF ready=1 tick=0",
                     an_o, seg_o, data_ready, frame_tick);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (an_o !== 4'hE || seg_o !== 8'hC0) begin
            errors++;
            $display("[TB] FAIL mid_digit0: an=%h seg=%h, want an=E seg=C0", an_o, seg_o);
        end
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_tick_timeout: tick=%b, want 1", frame_tick);
        end
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            checks++;
            if (an_o !== exp_an(s) || seg_o !== exp_seg(s, F_0000) || frame_tick !== (s == 15)) begin
                errors++;
                $display("[TB] FAIL mid_discard step %0d: an=%h seg=%h tick=%b, want an=%h seg=%h tick=%b",
                         s, an_o, seg_o, frame_tick, exp_an(s), exp_seg(s, F_0000), (s == 15));
            end
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_offer_full();
        test_boundary_accept();
        test_lzb();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
